// File: rtl/hdmi_audio_pkg.sv
// Shared definitions for the HDMI audio source scheduler.
//  - audio_state_t     : scheduler state encoding (IDLE, MUTE, ACTIVE)
//  - OWNER_W           : width of a source index
//  - MAX_SOURCES       : widest request mask the helpers accept
//  - lowest_set_index  : index of the lowest set bit (index 0 = highest priority)
package hdmi_audio_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MUTE   = 2'd1,
      ACTIVE = 2'd2
   } audio_state_t;

   localparam int OWNER_W     = 2;
   localparam int MAX_SOURCES = 4;

   // Walk from the top down so the last hit is the lowest index.
   // An empty mask returns 0; callers qualify the result with their own "any" flag.
   function automatic logic [OWNER_W-1:0] lowest_set_index(input logic [MAX_SOURCES-1:0] mask);
      logic [OWNER_W-1:0] idx;
      idx = '0;
      for (int i = MAX_SOURCES - 1; i >= 0; i--) begin
         if (mask[i]) idx = OWNER_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/audio_source_scheduler_if.sv
// Bundle between the audio requesters and the scheduler.
//  master : the audio sources (drive request/valid/sample, observe ready and the scheduler outputs)
//  slave  : the scheduler (consumes requests, drives src_ready and the packet_picker-facing outputs)
//  src_request/src_valid/src_ready : one bit per source
//  src_sample                      : slice i = {right,left} of source i
//  audio_sample_word               : {right,left} to packet_picker
//  audio_active, owner_id, switch_pulse, underrun_count : status
interface audio_source_scheduler_if #(
   parameter int AUDIO_BIT_WIDTH = 16,
   parameter int NUM_SOURCES     = 2
) ();

   logic [NUM_SOURCES-1:0]                   src_request;
   logic [NUM_SOURCES-1:0]                   src_valid;
   logic [NUM_SOURCES*2*AUDIO_BIT_WIDTH-1:0] src_sample;
   logic [NUM_SOURCES-1:0]                   src_ready;
   logic [2*AUDIO_BIT_WIDTH-1:0]             audio_sample_word;
   logic                                     audio_active;
   logic [hdmi_audio_pkg::OWNER_W-1:0]       owner_id;
   logic                                     switch_pulse;
   logic [7:0]                               underrun_count;

   modport master (
      output src_request, src_valid, src_sample,
      input  src_ready, audio_sample_word, audio_active, owner_id, switch_pulse, underrun_count
   );

   modport slave (
      input  src_request, src_valid, src_sample,
      output src_ready, audio_sample_word, audio_active, owner_id, switch_pulse, underrun_count
   );

endinterface

// File: rtl/audio_request_priority_encoder.sv
// Fixed-priority encoder over a request mask (index 0 highest).
//  mask    in  NUM_SOURCES  request bits
//  req_any out 1            at least one bit set
//  index   out OWNER_W      lowest set index (0 when mask is empty)
module audio_request_priority_encoder
   import hdmi_audio_pkg::*;
#(
   parameter int NUM_SOURCES = 2
) (
   input  logic [NUM_SOURCES-1:0] mask,
   output logic                   req_any,
   output logic [OWNER_W-1:0]     index
);

   logic [MAX_SOURCES-1:0] padded;

   assign padded  = MAX_SOURCES'(mask);
   assign req_any = |mask;
   assign index   = lowest_set_index(padded);

endmodule

// File: rtl/audio_source_scheduler.sv
// Shares the single HDMI audio sample path between NUM_SOURCES requesters.
// Fixed priority (index 0 highest), a zero-sample mute gap on every ownership change,
// and release of an owner that underruns UNDERRUN_LIMIT times in a row.
//  clk_audio  in  sample-rate clock, one sample word per cycle
//  reset      in  synchronous, active-high
//  bus        slave side of audio_source_scheduler_if (requests/samples in,
//             src_ready, audio_sample_word and status out)
module audio_source_scheduler
   import hdmi_audio_pkg::*;
#(
   parameter int AUDIO_BIT_WIDTH     = 16,
   parameter int NUM_SOURCES         = 2,
   parameter int SWITCH_MUTE_SAMPLES = 16,
   parameter int UNDERRUN_LIMIT      = 8
) (
   input logic                     clk_audio,
   input logic                     reset,
   audio_source_scheduler_if.slave bus
);

   localparam int          SAMPLE_W  = 2 * AUDIO_BIT_WIDTH;
   // A zero-length gap still spends one cycle in MUTE.
   localparam logic [15:0] MUTE_LOAD = (SWITCH_MUTE_SAMPLES == 0) ? 16'd0 : 16'(SWITCH_MUTE_SAMPLES - 1);
   localparam logic [7:0]  LIMIT     = 8'(UNDERRUN_LIMIT);

   audio_state_t           state, next_state;
   logic [OWNER_W-1:0]     owner, next_owner;
   logic [15:0]            mute_cnt;
   logic [7:0]             consec_underruns, consec_inc;
   logic [7:0]             total_underruns, total_inc;
   logic [SAMPLE_W-1:0]    word_q, owner_sample;
   logic                   active_q, pulse_q;
   logic [NUM_SOURCES-1:0] blocked, blocked_next;
   logic [NUM_SOURCES-1:0] owner_onehot, eff_request, other_request;
   logic                   owner_req, owner_valid, underrun_release;
   logic                   any_req, any_other;
   logic [OWNER_W-1:0]     low_idx, low_other;

   // Decode the owner register into a one-hot mask and pick its sample slice.
   always_comb begin
      owner_onehot = '0;
      owner_sample = '0;
      for (int i = 0; i < NUM_SOURCES; i++) begin
         if (owner == OWNER_W'(i)) begin
            owner_onehot[i] = 1'b1;
            owner_sample    = bus.src_sample[i*SAMPLE_W +: SAMPLE_W];
         end
      end
   end

   // A source released for underrun stays invisible until it drops its request once.
   assign eff_request   = bus.src_request & ~blocked;
   assign other_request = eff_request & ~owner_onehot;
   assign owner_req     = |(bus.src_request & owner_onehot);
   assign owner_valid   = |(bus.src_valid & owner_onehot);
   assign consec_inc    = (consec_underruns == 8'hFF) ? 8'hFF : consec_underruns + 8'd1;
   assign total_inc     = (total_underruns == 8'hFF) ? 8'hFF : total_underruns + 8'd1;

   audio_request_priority_encoder #(.NUM_SOURCES(NUM_SOURCES)) u_all_enc (
      .mask    (eff_request),
      .req_any (any_req),
      .index   (low_idx)
   );

   audio_request_priority_encoder #(.NUM_SOURCES(NUM_SOURCES)) u_other_enc (
      .mask    (other_request),
      .req_any (any_other),
      .index   (low_other)
   );

   // Next-state and ownership decision. At the end of a mute gap the lowest-index
   // requester wins; that is the pending owner whenever it is still the best choice.
   always_comb begin
      next_state       = state;
      next_owner       = owner;
      underrun_release = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               next_state = MUTE;
               next_owner = low_idx;
            end
         end
         MUTE: begin
            if (mute_cnt == 16'd0) begin
               if (any_req) begin
                  next_state = ACTIVE;
                  next_owner = low_idx;
               end else begin
                  next_state = IDLE;
                  next_owner = '0;
               end
            end
         end
         ACTIVE: begin
            underrun_release = !owner_valid && (consec_inc >= LIMIT);
            if (!owner_req || underrun_release) begin
               if (any_other) begin
                  next_state = MUTE;
                  next_owner = low_other;
               end else begin
                  next_state = IDLE;
                  next_owner = '0;
               end
            end else if (any_req && (low_idx < owner)) begin
               next_state = MUTE;
               next_owner = low_idx;
            end
         end
         default: begin
            next_state = IDLE;
            next_owner = '0;
         end
      endcase
   end

   always_comb begin
      blocked_next = blocked & bus.src_request;
      if (underrun_release) blocked_next = blocked_next | owner_onehot;
   end

   // Registered state, status outputs, sample word and underrun bookkeeping.
   always_ff @(posedge clk_audio) begin
      if (reset) begin
         state            <= IDLE;
         owner            <= '0;
         mute_cnt         <= '0;
         consec_underruns <= '0;
         total_underruns  <= '0;
         word_q           <= '0;
         active_q         <= 1'b0;
         pulse_q          <= 1'b0;
         blocked          <= '0;
      end else begin
         state    <= next_state;
         owner    <= next_owner;
         active_q <= (next_state == ACTIVE);
         pulse_q  <= (next_state == MUTE) && (state != MUTE);
         blocked  <= blocked_next;

         if ((next_state == MUTE) && (state != MUTE)) begin
            mute_cnt <= MUTE_LOAD;
         end else if ((state == MUTE) && (mute_cnt != 16'd0)) begin
            mute_cnt <= mute_cnt - 16'd1;
         end

         if (state == ACTIVE) begin
            if (owner_valid) begin
               word_q           <= owner_sample;
               consec_underruns <= '0;
            end else begin
               word_q           <= '0;
               consec_underruns <= consec_inc;
               total_underruns  <= total_inc;
            end
         end else begin
            word_q           <= '0;
            consec_underruns <= '0;
         end
      end
   end

   assign bus.src_ready         = (state == ACTIVE) ? owner_onehot : '0;
   assign bus.audio_sample_word = word_q;
   assign bus.audio_active      = active_q;
   assign bus.owner_id          = owner;
   assign bus.switch_pulse      = pulse_q;
   assign bus.underrun_count    = total_underruns;

endmodule

// File: tb/tb_audio_source_scheduler.sv
// Directed self-checking bench for audio_source_scheduler.
// Two instances: the default 16-sample gap build and a SWITCH_MUTE_SAMPLES=0 build.
// Expected sample words are queued as each cycle is driven and popped after the edge.
module tb_audio_source_scheduler;

   logic clk_audio = 1'b0;
   logic reset;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] exp_q[$];
   logic [31:0] exp_ng_q[$];

   audio_source_scheduler_if #(.AUDIO_BIT_WIDTH(16), .NUM_SOURCES(2)) bus ();
   audio_source_scheduler_if #(.AUDIO_BIT_WIDTH(16), .NUM_SOURCES(2)) bus_ng ();

   audio_source_scheduler #(
      .AUDIO_BIT_WIDTH(16), .NUM_SOURCES(2), .SWITCH_MUTE_SAMPLES(16), .UNDERRUN_LIMIT(8)
   ) u_dut (
      .clk_audio (clk_audio),
      .reset     (reset),
      .bus       (bus)
   );

   audio_source_scheduler #(
      .AUDIO_BIT_WIDTH(16), .NUM_SOURCES(2), .SWITCH_MUTE_SAMPLES(0), .UNDERRUN_LIMIT(8)
   ) u_dut_nogap (
      .clk_audio (clk_audio),
      .reset     (reset),
      .bus       (bus_ng)
   );

   always #5 clk_audio = ~clk_audio;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [1:0] req, input logic [1:0] vld, input logic [31:0] s0, input logic [31:0] s1);
      bus.src_request = req;
      bus.src_valid   = vld;
      bus.src_sample  = {s1, s0};
   endtask

   task automatic drive_ng(input logic [1:0] req, input logic [1:0] vld, input logic [31:0] s0, input logic [31:0] s1);
      bus_ng.src_request = req;
      bus_ng.src_valid   = vld;
      bus_ng.src_sample  = {s1, s0};
   endtask

   // One clock: queue the word expected after this edge, then compare it #1 later.
   task automatic step(input logic [31:0] exp_word);
      logic [31:0] e;
      exp_q.push_back(exp_word);
      @(posedge clk_audio);
      #1;
      e = exp_q.pop_front();
      check("word", bus.audio_sample_word, e);
   endtask

   task automatic step_ng(input logic [31:0] exp_word);
      logic [31:0] e;
      exp_ng_q.push_back(exp_word);
      @(posedge clk_audio);
      #1;
      e = exp_ng_q.pop_front();
      check("ng_word", bus_ng.audio_sample_word, e);
   endtask

   task automatic status(input string tag, input logic act, input logic [1:0] own, input logic [1:0] rdy, input logic pls);
      check({tag, "_active"}, bus.audio_active, act);
      check({tag, "_owner"},  bus.owner_id,     own);
      check({tag, "_ready"},  bus.src_ready,    rdy);
      check({tag, "_pulse"},  bus.switch_pulse, pls);
   endtask

   task automatic status_ng(input string tag, input logic act, input logic [1:0] own, input logic [1:0] rdy, input logic pls);
      check({tag, "_active"}, bus_ng.audio_active, act);
      check({tag, "_owner"},  bus_ng.owner_id,     own);
      check({tag, "_ready"},  bus_ng.src_ready,    rdy);
      check({tag, "_pulse"},  bus_ng.switch_pulse, pls);
   endtask

   initial begin
      reset = 1'b1;
      drive(2'b00, 2'b00, 32'h0, 32'h0);
      drive_ng(2'b00, 2'b00, 32'h0, 32'h0);
      step(32'h0);
      step(32'h0);
      status("reset", 1'b0, 2'd0, 2'b00, 1'b0);
      check("reset_underrun", bus.underrun_count, 8'd0);
      reset = 1'b0;

      // Source 0 alone: 16-cycle gap, then its samples one cycle after grant.
      drive(2'b01, 2'b01, 32'h1234_5678, 32'h0);
      step(32'h0);
      status("s1_enter", 1'b0, 2'd0, 2'b00, 1'b1);
      for (int i = 0; i < 15; i++) begin
         step(32'h0);
         status("s1_mute", 1'b0, 2'd0, 2'b00, 1'b0);
      end
      step(32'h0);
      status("s1_grant", 1'b1, 2'd0, 2'b01, 1'b0);
      step(32'h1234_5678);
      status("s1_run", 1'b1, 2'd0, 2'b01, 1'b0);
      drive(2'b01, 2'b01, 32'hAAAA_5555, 32'h0);
      step(32'hAAAA_5555);

      // Owner 0 drops while source 1 rises: one mute entry, exit cycle keeps owner 0 sample.
      drive(2'b10, 2'b11, 32'hAAAA_5555, 32'hBEEF_0001);
      step(32'hAAAA_5555);
      status("s2_enter", 1'b0, 2'd1, 2'b00, 1'b1);
      for (int i = 0; i < 15; i++) begin
         step(32'h0);
         status("s2_mute", 1'b0, 2'd1, 2'b00, 1'b0);
      end
      step(32'h0);
      status("s2_grant", 1'b1, 2'd1, 2'b10, 1'b0);
      step(32'hBEEF_0001);

      // Source 0 returns and preempts owner 1.
      drive(2'b11, 2'b11, 32'hAAAA_5555, 32'hBEEF_0001);
      step(32'hBEEF_0001);
      status("s3_enter", 1'b0, 2'd0, 2'b00, 1'b1);
      for (int i = 0; i < 15; i++) begin
         step(32'h0);
         status("s3_mute", 1'b0, 2'd0, 2'b00, 1'b0);
      end
      step(32'h0);
      status("s3_grant", 1'b1, 2'd0, 2'b01, 1'b0);
      step(32'hAAAA_5555);

      // Persistent underrun of owner 0 with nobody else requesting: release to IDLE.
      drive(2'b01, 2'b00, 32'hAAAA_5555, 32'h0);
      for (int i = 1; i <= 7; i++) begin
         step(32'h0);
         check("s4_underrun", bus.underrun_count, 8'(i));
         check("s4_active", bus.audio_active, 1'b1);
      end
      step(32'h0);
      check("s4_underrun_final", bus.underrun_count, 8'd8);
      status("s4_release", 1'b0, 2'd0, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(32'h0);
         status("s4_blocked", 1'b0, 2'd0, 2'b00, 1'b0);
      end
      drive(2'b00, 2'b01, 32'hCAFE_0001, 32'h0);
      step(32'h0);
      status("s4_drop", 1'b0, 2'd0, 2'b00, 1'b0);
      drive(2'b01, 2'b01, 32'hCAFE_0001, 32'h0);
      step(32'h0);
      status("s4_reenter", 1'b0, 2'd0, 2'b00, 1'b1);
      for (int i = 0; i < 15; i++) step(32'h0);
      step(32'h0);
      status("s4_regrant", 1'b1, 2'd0, 2'b01, 1'b0);
      step(32'hCAFE_0001);
      check("s4_underrun_hold", bus.underrun_count, 8'd8);

      // Reset in the middle of a gap (counter at 7) restarts a full gap.
      drive(2'b10, 2'b11, 32'h0BAD_F00D, 32'h5151_A2A2);
      step(32'h0BAD_F00D);
      status("s5_enter", 1'b0, 2'd1, 2'b00, 1'b1);
      for (int i = 0; i < 8; i++) step(32'h0);
      reset = 1'b1;
      step(32'h0);
      status("s5_reset", 1'b0, 2'd0, 2'b00, 1'b0);
      check("s5_reset_underrun", bus.underrun_count, 8'd0);
      reset = 1'b0;
      step(32'h0);
      status("s5_enter2", 1'b0, 2'd1, 2'b00, 1'b1);
      for (int i = 0; i < 15; i++) begin
         step(32'h0);
         status("s5_mute", 1'b0, 2'd1, 2'b00, 1'b0);
      end
      step(32'h0);
      status("s5_grant", 1'b1, 2'd1, 2'b10, 1'b0);
      step(32'h5151_A2A2);

      // Zero-gap build: a switch costs exactly one zero word and no src_ready.
      drive(2'b00, 2'b00, 32'h0, 32'h0);
      reset = 1'b1;
      step_ng(32'h0);
      reset = 1'b0;
      drive_ng(2'b01, 2'b01, 32'h1111_2222, 32'h3333_4444);
      step_ng(32'h0);
      status_ng("ng_enter", 1'b0, 2'd0, 2'b00, 1'b1);
      step_ng(32'h0);
      status_ng("ng_grant", 1'b1, 2'd0, 2'b01, 1'b0);
      step_ng(32'h1111_2222);
      drive_ng(2'b10, 2'b11, 32'h1111_2222, 32'h3333_4444);
      step_ng(32'h1111_2222);
      status_ng("ng_switch", 1'b0, 2'd1, 2'b00, 1'b1);
      step_ng(32'h0);
      status_ng("ng_grant1", 1'b1, 2'd1, 2'b10, 1'b0);
      step_ng(32'h3333_4444);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
